// File: rtl/edge_mem_host.sv
`default_nettype none
// ============================================================================
// Module      : edge_mem_host
// Description : Memory responder and host sequencer wrapped around the
//               edge-detection accelerator. Owns the word-addressed 32-bit
//               image memory and walks through four phases:
//                 LOAD  - packs host bytes (LSB first) into words at 0..
//                 RUN   - holds start high and serves accelerator accesses
//                 FETCH/SEND - streams the result region back as bytes
//                 DONE  - raises done until the next reset
// Ports       :
//   clk, reset            clock, synchronous active-high reset
//   addr/dataR/dataW/en/we accelerator single-port memory interface
//   start / finish         run request / completion handshake
//   in_data/in_valid/in_ready    host byte stream into the memory
//   out_data/out_valid/out_ready result byte stream back to the host
//   done                   result stream complete
// Revision    : 1.0 - initial release
// ============================================================================
module edge_mem_host #(
    parameter int IMG_WORDS = 25344,
    parameter int RES_BASE  = 25344,
    parameter int DEPTH     = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    output logic [31:0] dataR,
    input  logic [31:0] dataW,
    input  logic        en,
    input  logic        we,
    output logic        start,
    input  logic        finish,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_RUN   = 3'd1,
        S_FETCH = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] c_LAST_LOAD = 16'(IMG_WORDS - 1);
    localparam logic [15:0] c_RES_BASE  = 16'(RES_BASE);
    localparam logic [15:0] c_LAST_DUMP = 16'(RES_BASE + IMG_WORDS - 1);

    state_t      r_state;
    logic [31:0] r_mem [0:DEPTH-1];
    logic [15:0] r_load_addr;
    logic [15:0] r_dump_addr;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_pack;        // lanes 0..2; lane 3 comes straight from in_data
    logic [31:0] r_fetch_word;  // memory word read in the first FETCH cycle
    logic [31:0] r_shift;       // outgoing word, current byte always in [7:0]
    logic [31:0] r_dataR;
    logic        r_fetch_ph;
    logic        r_start;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_done;

    logic        w_addr_ok;
    logic        w_load_fire;
    logic        w_mem_we;
    logic [15:0] w_mem_waddr;
    logic [31:0] w_mem_wdata;

    assign w_addr_ok   = ({16'd0, addr} < 32'(DEPTH));
    assign w_load_fire = (r_state == S_LOAD) && in_valid && r_in_ready;

    // Single write port shared by the host loader and the accelerator; the
    // two owners are never active in the same state.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = addr;
        w_mem_wdata = dataW;
        if (!reset) begin
            if (w_load_fire && (r_byte_idx == 2'd3)) begin
                w_mem_we    = 1'b1;
                w_mem_waddr = r_load_addr;
                w_mem_wdata = {in_data, r_pack};
            end else if ((r_state == S_RUN) && en && we && w_addr_ok) begin
                w_mem_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_LOAD;
            r_load_addr  <= 16'd0;
            r_dump_addr  <= 16'd0;
            r_byte_idx   <= 2'd0;
            r_pack       <= 24'd0;
            r_fetch_word <= 32'd0;
            r_shift      <= 32'd0;
            r_dataR      <= 32'd0;
            r_fetch_ph   <= 1'b0;
            r_start      <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_load_fire) begin
                        case (r_byte_idx)
                            2'd0:    r_pack[7:0]   <= in_data;
                            2'd1:    r_pack[15:8]  <= in_data;
                            2'd2:    r_pack[23:16] <= in_data;
                            default: ;
                        endcase
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_load_addr <= r_load_addr + 16'd1;
                            if (r_load_addr == c_LAST_LOAD) begin
                                r_in_ready <= 1'b0;
                                r_start    <= 1'b1;
                                r_state    <= S_RUN;
                            end
                        end
                    end
                end

                S_RUN: begin
                    // Read result stays on dataR until the next read.
                    if (en && !we) begin
                        r_dataR <= w_addr_ok ? r_mem[addr] : 32'd0;
                    end
                    if (finish) begin
                        r_start     <= 1'b0;
                        r_dump_addr <= c_RES_BASE;
                        r_fetch_ph  <= 1'b0;
                        r_state     <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (!r_fetch_ph) begin
                        r_fetch_word <= r_mem[r_dump_addr];
                        r_fetch_ph   <= 1'b1;
                    end else begin
                        r_shift     <= r_fetch_word;
                        r_out_valid <= 1'b1;
                        r_byte_idx  <= 2'd0;
                        r_fetch_ph  <= 1'b0;
                        r_state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (out_ready) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_shift    <= r_shift >> 8;
                        if (r_byte_idx == 2'd3) begin
                            r_out_valid <= 1'b0;
                            r_dump_addr <= r_dump_addr + 16'd1;
                            if (r_dump_addr == c_LAST_DUMP) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end
                    end
                end

                S_DONE: begin
                    r_done      <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_start     <= 1'b0;
                    r_in_ready  <= 1'b0;
                end

                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign dataR     = r_dataR;
    assign start     = r_start;
    assign in_ready  = r_in_ready;
    assign out_data  = r_shift[7:0];
    assign out_valid = r_out_valid;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_edge_mem_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_mem_host
// Description : Self-checking bench for edge_mem_host. A small image keeps
//               the run short; a plain word array models the memory and the
//               byte streams are derived from it with simple arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_mem_host;

    localparam int IMG_WORDS = 64;
    localparam int RES_BASE  = 64;
    localparam int NB        = IMG_WORDS * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [31:0] dataW;
    logic        en;
    logic        we;
    logic        finish;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        out_ready;
    wire  [31:0] dataR;
    wire         start;
    wire         in_ready;
    wire  [7:0]  out_data;
    wire         out_valid;
    wire         done;

    logic [31:0] ref_mem [0:65535];
    int          n_vec = 0;
    int          n_err = 0;

    edge_mem_host #(
        .IMG_WORDS (IMG_WORDS),
        .RES_BASE  (RES_BASE),
        .DEPTH     (65536)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .dataR     (dataR),
        .dataW     (dataW),
        .en        (en),
        .we        (we),
        .start     (start),
        .finish    (finish),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_read(input logic [15:0] a);
        en = 1'b1; we = 1'b0; addr = a;
        step();
        en = 1'b0;
    endtask

    task automatic acc_write(input logic [15:0] a, input logic [31:0] d);
        en = 1'b1; we = 1'b1; addr = a; dataW = d;
        step();
        en = 1'b0; we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Streams a full image; pattern mode sends byte n = n mod 256.
    task automatic load_image(input bit pat);
        int  n   = 0;
        int  cyc = 0;
        bit  v;
        bit  fire;
        logic [7:0] b;
        while (n < NB && cyc < 4000) begin
            v = ($urandom_range(0, 3) != 0);
            b = pat ? 8'(n) : 8'($urandom);
            in_data  = b;
            in_valid = v;
            fire = v && in_ready;
            step();
            cyc++;
            if (fire) begin
                ref_mem[n / 4][8 * (n % 4) +: 8] = b;
                n++;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (n !== NB) begin
            n_err++;
            $display("FAIL load_count: accepted %0d bytes, required %0d", n, NB);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_in_ready_drop: in_ready=%b required 0", in_ready);
        end
        n_vec++;
        if (start !== 1'b1) begin
            n_err++;
            $display("FAIL load_start_rise: start=%b required 1", start);
        end
    endtask

    // Drains the result stream; mode 0 toggles out_ready, mode 1 randomises.
    task automatic dump(input int max_bytes, input int mode, output int nb);
        int   cyc = 0;
        bit   rdy;
        bit   stalled = 1'b0;
        logic [7:0] held = 8'd0;
        logic [7:0] exp_b;
        nb = 0;
        while (nb < max_bytes && done !== 1'b1 && cyc < 6000) begin
            rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc % 2 == 0);
            out_ready = rdy;
            if (out_valid === 1'b1) begin
                if (stalled) begin
                    n_vec++;
                    if (out_data !== held) begin
                        n_err++;
                        $display("FAIL stall_stable: out_data=%h required %h", out_data, held);
                    end
                end
                exp_b = ref_mem[RES_BASE + nb / 4][8 * (nb % 4) +: 8];
                n_vec++;
                if (out_data !== exp_b) begin
                    n_err++;
                    $display("FAIL out_byte[%0d]: out_data=%h required %h", nb, out_data, exp_b);
                end
                held    = out_data;
                stalled = !rdy;
                if (rdy) nb++;
            end else begin
                stalled = 1'b0;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_vec++;
        if ({dataR, start, in_ready, out_valid, out_data, done} !== 44'd0) begin
            n_err++;
            $display("FAIL reset_values: dataR=%h start=%b in_ready=%b out_valid=%b out_data=%h done=%b required all 0",
                     dataR, start, in_ready, out_valid, out_data, done);
        end
        reset = 1'b0;
        step();
        n_vec++;
        if (in_ready !== 1'b1 || start !== 1'b0) begin
            n_err++;
            $display("FAIL load_entry: in_ready=%b start=%b required 1/0", in_ready, start);
        end
    endtask

    task automatic test_load_and_read();
        logic [31:0] last;
        logic [15:0] a;
        load_image(1'b1);
        acc_read(16'd5);
        n_vec++;
        if (dataR !== ref_mem[5]) begin
            n_err++;
            $display("FAIL read_addr5: dataR=%h required %h", dataR, ref_mem[5]);
        end
        last = ref_mem[5];
        addr = 16'($urandom);
        repeat (3) step();
        n_vec++;
        if (dataR !== last) begin
            n_err++;
            $display("FAIL read_hold: dataR=%h required %h", dataR, last);
        end
        acc_read(16'd0);
        n_vec++;
        if (dataR !== ref_mem[0]) begin
            n_err++;
            $display("FAIL read_first_word: dataR=%h required %h", dataR, ref_mem[0]);
        end
        acc_read(16'(IMG_WORDS - 1));
        n_vec++;
        if (dataR !== ref_mem[IMG_WORDS - 1]) begin
            n_err++;
            $display("FAIL read_last_word: dataR=%h required %h", dataR, ref_mem[IMG_WORDS - 1]);
        end
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom_range(0, IMG_WORDS - 1));
            acc_read(a);
            if ($urandom_range(0, 1) == 1) step();
            n_vec++;
            if (dataR !== ref_mem[a]) begin
                n_err++;
                $display("FAIL read_random[%0d]: dataR=%h required %h", a, dataR, ref_mem[a]);
            end
        end
    endtask

    task automatic test_write();
        logic [31:0] last;
        logic [31:0] d;
        last = dataR;
        acc_write(16'(RES_BASE), 32'hA5A5A5A5);
        n_vec++;
        if (dataR !== last) begin
            n_err++;
            $display("FAIL write_keeps_dataR: dataR=%h required %h", dataR, last);
        end
        acc_read(16'(RES_BASE));
        n_vec++;
        if (dataR !== ref_mem[RES_BASE]) begin
            n_err++;
            $display("FAIL write_readback: dataR=%h required %h", dataR, ref_mem[RES_BASE]);
        end
        d = $urandom;
        acc_write(16'hFFFF, d);
        acc_read(16'hFFFF);
        n_vec++;
        if (dataR !== ref_mem[16'hFFFF]) begin
            n_err++;
            $display("FAIL write_top_addr: dataR=%h required %h", dataR, ref_mem[16'hFFFF]);
        end
        acc_read(16'(RES_BASE));
        n_vec++;
        if (dataR !== ref_mem[RES_BASE]) begin
            n_err++;
            $display("FAIL top_write_isolation_res: dataR=%h required %h", dataR, ref_mem[RES_BASE]);
        end
        acc_read(16'd0);
        n_vec++;
        if (dataR !== ref_mem[0]) begin
            n_err++;
            $display("FAIL top_write_isolation_0: dataR=%h required %h", dataR, ref_mem[0]);
        end
        // Fill the result region except its last word, which goes in with finish.
        for (int i = 0; i < IMG_WORDS - 1; i++) begin
            acc_write(16'(RES_BASE + i), (i == 0) ? 32'h44332211 : $urandom);
        end
    endtask

    task automatic test_finish_and_dump();
        int nb;
        en = 1'b1; we = 1'b1; addr = 16'(RES_BASE + IMG_WORDS - 1); dataW = $urandom;
        ref_mem[RES_BASE + IMG_WORDS - 1] = dataW;
        finish = 1'b1;
        step();
        en = 1'b0; we = 1'b0; finish = 1'b0;
        n_vec++;
        if (start !== 1'b0) begin
            n_err++;
            $display("FAIL finish_start_fall: start=%b required 0", start);
        end
        dump(NB, 0, nb);
        n_vec++;
        if (nb !== NB) begin
            n_err++;
            $display("FAIL dump_count: got %0d bytes, required %0d", nb, NB);
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL done_rise: done=%b required 1", done);
        end
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            n_vec++;
            if (out_valid !== 1'b0 || done !== 1'b1 || start !== 1'b0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL done_sticky: out_valid=%b done=%b start=%b in_ready=%b required 0/1/0/0",
                         out_valid, done, start, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nb;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        load_image(1'b0);
        finish = 1'b1;
        step();
        finish = 1'b0;
        dump(6, 1, nb);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_send_reached: out_valid=%b required 1", out_valid);
        end
        reset = 1'b1;
        step();
        n_vec++;
        if (out_valid !== 1'b0 || done !== 1'b0 || start !== 1'b0 || dataR !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset_values: out_valid=%b done=%b start=%b dataR=%h required 0",
                     out_valid, done, start, dataR);
        end
        reset = 1'b0;
        step();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_load: in_ready=%b out_valid=%b done=%b required 1/0/0",
                     in_ready, out_valid, done);
        end
        // Three bytes of a word, then reset: those bytes must not survive.
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        load_image(1'b0);
        for (int i = 0; i < 3; i++) begin
            acc_read(16'(i));
            n_vec++;
            if (dataR !== ref_mem[i]) begin
                n_err++;
                $display("FAIL partial_discard[%0d]: dataR=%h required %h", i, dataR, ref_mem[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; addr = '0; dataW = '0; en = 1'b0; we = 1'b0; finish = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_load_and_read();
        test_write();
        test_finish_and_dump();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
